// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - data memory load/store unit with fixed accept-to-response latency
//
// Single-port word memory with byte-lane writes. It takes one request at a time
// and answers every accepted request with exactly one response pulse, READ_LAT
// cycles after the accept edge.
//
// Ports:
//   clk         in   clock, all state on the rising edge
//   rst_n       in   synchronous active-low reset (memory contents are kept)
//   req_valid   in   request present
//   req_ready   out  request can be accepted this cycle
//   req_we      in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_funct3  in   RV32I size/sign code
//   req_wdata   in   right-aligned store data
//   rsp_valid   out  one-cycle response pulse
//   rsp_rdata   out  extended load data, 0 for stores, faults and idle cycles
//   rsp_err     out  request faulted, qualified by rsp_valid
module dmem_lsu #(
  parameter int DEPTH_WORDS = 256,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] LAST = 2'(READ_LAT - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        accept;

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          out_of_range;
  logic          bad_funct3;
  logic          misaligned;
  logic          req_err;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] load_data;
  logic [31:0] acc_data;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        wr_en;

  logic        pv_q [READ_LAT];
  logic [31:0] pd_q [READ_LAT];
  logic        pe_q [READ_LAT];

  // Ready is forced low combinationally while reset is held, so nothing can be
  // accepted (or written) during a reset cycle.
  assign req_ready = rst_n & ready_q;
  assign accept    = req_valid & req_ready;

  // ------------------------------------------------------------------
  // Request decode
  // ------------------------------------------------------------------
  assign word_idx     = req_addr[AW+1:2];
  assign lane         = req_addr[1:0];
  assign out_of_range = |req_addr[31:AW+2];

  always_comb begin
    bad_funct3 = 1'b0;
    if (req_we) begin
      bad_funct3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      bad_funct3 = req_funct3 inside {3'b011, 3'b110, 3'b111};
    end
  end

  assign misaligned = ((req_funct3[1:0] == 2'b01) && lane[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (lane != 2'b00));

  assign req_err = bad_funct3 | misaligned | out_of_range;

  // ------------------------------------------------------------------
  // Load path: read the addressed word, move the addressed lane to bit 0
  // ------------------------------------------------------------------
  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    load_data = 32'h0;
    case (req_funct3)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'h0, rd_shift[7:0]};
      3'b101:  load_data = {16'h0, rd_shift[15:0]};
      default: load_data = 32'h0;
    endcase
  end

  // Stores and faulted requests always answer with zero data.
  assign acc_data = (req_we || req_err) ? 32'h0 : load_data;

  // ------------------------------------------------------------------
  // Store path: replicate data across lanes, enable only addressed lanes
  // ------------------------------------------------------------------
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = 4'b0011 << lane;
        wr_data = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_data = req_wdata;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = req_wdata;
      end
    endcase
  end

  assign wr_en = accept & req_we & ~req_err;

  // No reset: memory contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Control FSM: BUSY lasts READ_LAT cycles, the last one overlapping the
  // response so a new request can be taken back-to-back.
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = 2'd0;
        end
      end
      BUSY: begin
        if (cnt_q == LAST) begin
          if (accept) begin
            cnt_d = 2'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
    ready_d = (state_d == IDLE) || (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // ------------------------------------------------------------------
  // Response pipeline: stage 0 captures at the accept edge, the last stage
  // drives the outputs. Empty stages carry zero data and error.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pd_q[i] <= 32'h0;
        pe_q[i] <= 1'b0;
      end
    end else begin
      pv_q[0] <= accept;
      pd_q[0] <= accept ? acc_data : 32'h0;
      pe_q[0] <= accept & req_err;
      for (int i = 1; i < READ_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

  assign rsp_valid = pv_q[READ_LAT-1];
  assign rsp_rdata = pd_q[READ_LAT-1];
  assign rsp_err   = pe_q[READ_LAT-1];

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu at READ_LAT 1, 2 and 3
module tb_dmem_lsu;

  localparam int NI    = 3;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_we     [NI];
  logic [31:0] req_addr   [NI];
  logic [2:0]  req_funct3 [NI];
  logic [31:0] req_wdata  [NI];
  logic        rsp_valid  [NI];
  logic [31:0] rsp_rdata  [NI];
  logic        rsp_err    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_lsu #(.DEPTH_WORDS(DEPTH), .READ_LAT(g + 1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_funct3 (req_funct3[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g])
    );
  end

  // Reference model: byte-addressed memory plus at most one pending response
  logic [7:0]  mem_m [NI][4*DEPTH];
  bit          pend      [NI];
  int          due       [NI];
  logic [31:0] pend_data [NI];
  bit          pend_err  [NI];
  bit          chk_on    [NI];
  bit          acc       [NI];
  int          acc_cyc   [NI];
  logic [31:0] last_rdata   [NI];
  bit          last_err     [NI];
  int          last_rsp_cyc [NI];
  int          rsp_cnt      [NI];
  int          edge_no;
  int unsigned n_vec;
  int unsigned n_err;

  function automatic bit req_fault(bit we, logic [2:0] f3, logic [31:0] a);
    bit legal;
    int sz;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    sz = 1 << f3[1:0];
    return !legal || ((a % sz) != 0) || (a >= 32'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] load_val(int i, logic [2:0] f3, logic [31:0] a);
    int sz;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    v  = 32'h0;
    for (int k = sz - 1; k >= 0; k--) v = (v << 8) | 32'(mem_m[i][a + k]);
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic check(int i, string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (lat%0d): got %h, expected %h, cycle %0d", name, i + 1, act, exp, edge_no);
    end
  endtask

  // One clock: compare every instance at the falling edge, then advance the
  // model at the rising edge.
  task automatic tick();
    bit          exp_v, exp_r, exp_e, f;
    logic [31:0] exp_d;
    int          sz;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      exp_v  = pend[i] && (due[i] == edge_no);
      exp_d  = exp_v ? pend_data[i] : 32'h0;
      exp_e  = exp_v && pend_err[i];
      exp_r  = rst_n[i] && (!pend[i] || (due[i] == edge_no));
      acc[i] = req_valid[i] && exp_r;
      if (chk_on[i]) begin
        check(i, "req_ready", 32'(req_ready[i]), 32'(exp_r));
        check(i, "rsp_valid", 32'(rsp_valid[i]), 32'(exp_v));
        check(i, "rsp_rdata", rsp_rdata[i], exp_d);
        check(i, "rsp_err",   32'(rsp_err[i]), 32'(exp_e));
        if (rsp_valid[i]) begin
          last_rdata[i]   = rsp_rdata[i];
          last_err[i]     = rsp_err[i];
          last_rsp_cyc[i] = edge_no;
          rsp_cnt[i]++;
        end
      end
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (pend[i] && (due[i] == edge_no)) pend[i] = 1'b0;
      if (!rst_n[i]) begin
        pend[i]   = 1'b0;
        chk_on[i] = 1'b1;
      end else if (acc[i]) begin
        f            = req_fault(req_we[i], req_funct3[i], req_addr[i]);
        pend[i]      = 1'b1;
        due[i]       = edge_no + 1 + i;
        pend_err[i]  = f;
        pend_data[i] = (f || req_we[i]) ? 32'h0 : load_val(i, req_funct3[i], req_addr[i]);
        if (!f && req_we[i]) begin
          sz = 1 << req_funct3[i][1:0];
          for (int k = 0; k < sz; k++) mem_m[i][req_addr[i] + k] = req_wdata[i][8*k +: 8];
        end
      end
    end
    edge_no++;
    #1;
  endtask

  // Present a request and hold it until accepted; req_valid is left high.
  task automatic issue(int i, bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    int guard;
    guard         = 0;
    req_we[i]     = we;
    req_funct3[i] = f3;
    req_addr[i]   = a;
    req_wdata[i]  = wd;
    req_valid[i]  = 1'b1;
    do begin
      tick();
      guard++;
    end while (!acc[i] && guard < 20);
    if (!acc[i]) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout (lat%0d): no accept in %0d cycles", i + 1, guard);
    end
    acc_cyc[i] = edge_no;
  endtask

  // Single request, then idle long enough to observe its response.
  task automatic xact(int i, bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    issue(i, we, f3, a, wd);
    req_valid[i] = 1'b0;
    repeat (i + 1) tick();
  endtask

  task automatic expect_rsp(int i, string name, logic [31:0] d, bit e);
    check(i, {name, "_latency"}, 32'(last_rsp_cyc[i] - acc_cyc[i]), 32'(i));
    check(i, {name, "_rdata"}, last_rdata[i], d);
    check(i, {name, "_err"}, 32'(last_err[i]), 32'(e));
  endtask

  logic [2:0] ld_tab [5];
  int         e [4];
  int         cnt0;
  bit         rwe;
  logic [2:0] rf3;
  logic [31:0] raddr;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    edge_no = 0;
    ld_tab  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_addr[i] = 32'h0; req_funct3[i] = 3'd0; req_wdata[i] = 32'h0;
      pend[i] = 1'b0; due[i] = 0; pend_data[i] = 32'h0; pend_err[i] = 1'b0;
      chk_on[i] = 1'b0; acc[i] = 1'b0; acc_cyc[i] = 0; rsp_cnt[i] = 0;
      last_rdata[i] = 32'h0; last_err[i] = 1'b0; last_rsp_cyc[i] = -1;
      for (int b = 0; b < 4 * DEPTH; b++) mem_m[i][b] = 8'h00;
    end

    // Reset state
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      check(i, "reset_ready", 32'(req_ready[i]), 32'd0);
      check(i, "reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check(i, "reset_rsp_rdata", rsp_rdata[i], 32'd0);
      check(i, "reset_rsp_err", 32'(rsp_err[i]), 32'd0);
      rst_n[i] = 1'b1;
    end
    #1;
    for (int i = 0; i < NI; i++) check(i, "release_ready", 32'(req_ready[i]), 32'd1);

    // Store then load of a full word at latency 1
    xact(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    expect_rsp(0, "sw", 32'h0, 1'b0);
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0);
    expect_rsp(0, "lw", 32'hDEADBEEF, 1'b0);

    // Byte store into a zero word, read back three ways
    xact(1, 1'b1, 3'b000, 32'h13, 32'h80);
    expect_rsp(1, "sb", 32'h0, 1'b0);
    xact(1, 1'b0, 3'b000, 32'h13, 32'h0);
    expect_rsp(1, "lb", 32'hFFFFFF80, 1'b0);
    xact(1, 1'b0, 3'b100, 32'h13, 32'h0);
    expect_rsp(1, "lbu", 32'h00000080, 1'b0);
    xact(1, 1'b0, 3'b010, 32'h10, 32'h0);
    expect_rsp(1, "lw_word", 32'h80000000, 1'b0);

    // Faults: misaligned half/word, out of range, illegal codes
    xact(0, 1'b0, 3'b001, 32'h11, 32'h0);
    expect_rsp(0, "lh_misaligned", 32'h0, 1'b1);
    xact(0, 1'b1, 3'b010, 32'h22, 32'hA5A5A5A5);
    expect_rsp(0, "sw_misaligned", 32'h0, 1'b1);
    xact(0, 1'b0, 3'b010, 32'h400, 32'h0);
    expect_rsp(0, "lw_range", 32'h0, 1'b1);
    xact(0, 1'b0, 3'b011, 32'h20, 32'h0);
    expect_rsp(0, "load_f3_011", 32'h0, 1'b1);
    xact(0, 1'b1, 3'b100, 32'h20, 32'hFFFFFFFF);
    expect_rsp(0, "store_f3_100", 32'h0, 1'b1);
    xact(0, 1'b0, 3'b010, 32'h20, 32'h0);
    expect_rsp(0, "word20_unchanged", 32'h0, 1'b0);

    // Latency 3 with req_valid held high across back-to-back requests
    cnt0 = rsp_cnt[2];
    for (int k = 0; k < 4; k++) issue(2, 1'b1, 3'b010, 32'(4 * k), 32'h11111111 * (k + 1));
    for (int k = 0; k < 4; k++) begin
      issue(2, 1'b0, 3'b010, 32'(4 * k), 32'h0);
      e[k] = acc_cyc[2];
    end
    req_valid[2] = 1'b0;
    repeat (3) tick();
    for (int k = 1; k < 4; k++) check(2, "b2b_spacing", 32'(e[k] - e[k-1]), 32'd3);
    check(2, "b2b_rsp_count", 32'(rsp_cnt[2] - cnt0), 32'd8);
    expect_rsp(2, "b2b_last_lw", 32'h44444444, 1'b0);

    // Reset with a load in flight, then with a store just accepted
    xact(1, 1'b1, 3'b010, 32'h40, 32'h12345678);
    issue(1, 1'b0, 3'b010, 32'h40, 32'h0);
    req_valid[1] = 1'b0;
    cnt0 = rsp_cnt[1];
    rst_n[1] = 1'b0;
    tick();
    rst_n[1] = 1'b1;
    #1;
    check(1, "post_reset_ready", 32'(req_ready[1]), 32'd1);
    repeat (3) tick();
    check(1, "dropped_rsp", 32'(rsp_cnt[1] - cnt0), 32'd0);
    issue(1, 1'b1, 3'b010, 32'h44, 32'hCAFEF00D);
    req_valid[1] = 1'b0;
    rst_n[1] = 1'b0;
    tick();
    rst_n[1] = 1'b1;
    tick();
    xact(1, 1'b0, 3'b010, 32'h40, 32'h0);
    expect_rsp(1, "mem_after_reset", 32'h12345678, 1'b0);
    xact(1, 1'b0, 3'b010, 32'h44, 32'h0);
    expect_rsp(1, "store_before_reset", 32'hCAFEF00D, 1'b0);

    // Randomised traffic, one instance at a time
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 150; n++) begin
        rwe = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) < 8) rf3 = rwe ? 3'($urandom_range(0, 2)) : ld_tab[$urandom_range(0, 4)];
        else rf3 = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 19) == 0) raddr = $urandom();
        else raddr = 32'($urandom_range(0, 127));
        if ($urandom_range(0, 3) != 0) raddr = raddr & ~((32'd1 << rf3[1:0]) - 32'd1);
        issue(i, rwe, rf3, raddr, $urandom());
        if ($urandom_range(0, 1) == 0) begin
          req_valid[i] = 1'b0;
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      req_valid[i] = 1'b0;
      repeat (5) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
